// File: rtl/usb_uart_bridge_pkg.sv
// Shared definitions for the USB-to-UART bridge: FSM state encodings used by
// both the host-to-serial and serial-to-host paths.
package usb_uart_bridge_pkg;

  localparam int BYTE_W = 8;

  typedef logic [1:0] uart_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/usb_uart_bridge_if.sv
// Byte-side handshake between the USB serial core (master) and the bridge (slave).
interface usb_uart_bridge_if;
  logic [7:0] usb_rx_data;
  logic       usb_rx_ready;
  logic       usb_rx_strobe;
  logic [7:0] usb_tx_data;
  logic       usb_tx_strobe;
  logic       usb_tx_ready;

  modport master (
    output usb_rx_data, usb_rx_ready, usb_tx_ready,
    input  usb_rx_strobe, usb_tx_data, usb_tx_strobe
  );

  modport slave (
    input  usb_rx_data, usb_rx_ready, usb_tx_ready,
    output usb_rx_strobe, usb_tx_data, usb_tx_strobe
  );
endinterface

// File: rtl/usb_uart_fifo.sv
// Receive FIFO: power-of-two depth, extra pointer MSB distinguishes full from
// empty, head is read combinationally so a pop can happen in the same cycle.
module usb_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A push while full is dropped even if a pop happens in the same cycle.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/usb_uart_bridge.sv
// Full-duplex bridge: host bytes are serialised 8N1 on serial_txd, bytes
// received on serial_rxd are buffered in a FIFO and handed to the USB core.
module usb_uart_bridge
  import usb_uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 417,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               reset,
  usb_uart_bridge_if.slave   usb,
  output logic               serial_txd,
  input  logic               serial_rxd,
  output logic               rx_overrun,
  output logic               rx_frame_err
);

  localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------- host -> serial ----------------
  uart_state_t       r_tx_state;
  logic [CW-1:0]     r_tx_cnt;
  logic [2:0]        r_tx_bit;
  logic [7:0]        r_tx_shift;
  logic              r_txd;
  logic [1:0]        r_holdoff;
  logic              w_tx_bit_end;
  logic              w_take;

  assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);
  // Taking the next byte on the last stop-bit cycle keeps back-to-back frames gapless.
  assign w_take = !reset && usb.usb_rx_ready && (r_holdoff == 2'd0) &&
                  ((r_tx_state == ST_IDLE) || ((r_tx_state == ST_STOP) && w_tx_bit_end));
  assign usb.usb_rx_strobe = w_take;
  assign serial_txd        = r_txd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
      r_holdoff  <= '0;
    end else begin
      if (w_take)                 r_holdoff <= 2'd2;
      else if (r_holdoff != 2'd0) r_holdoff <= r_holdoff - 1'b1;

      if (w_take) begin
        r_tx_shift <= usb.usb_rx_data;
        r_tx_state <= ST_START;
        r_tx_cnt   <= '0;
        r_txd      <= 1'b0;
      end else begin
        case (r_tx_state)
          ST_IDLE: begin
            r_txd <= 1'b1;
          end
          ST_START: begin
            if (w_tx_bit_end) begin
              r_tx_cnt   <= '0;
              r_tx_bit   <= '0;
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_state <= ST_DATA;
            end else begin
              r_tx_cnt <= r_tx_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (w_tx_bit_end) begin
              r_tx_cnt <= '0;
              if (r_tx_bit == 3'd7) begin
                r_txd      <= 1'b1;
                r_tx_state <= ST_STOP;
              end else begin
                r_txd      <= r_tx_shift[0];
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_bit   <= r_tx_bit + 1'b1;
              end
            end else begin
              r_tx_cnt <= r_tx_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (w_tx_bit_end) begin
              r_tx_cnt   <= '0;
              r_tx_state <= ST_IDLE;
            end else begin
              r_tx_cnt <= r_tx_cnt + 1'b1;
            end
          end
          default: r_tx_state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------- serial -> host ----------------
  logic              r_sync1;
  logic              r_sync2;
  uart_state_t       r_rx_state;
  logic [CW-1:0]     r_rx_cnt;
  logic [2:0]        r_rx_bit;
  logic [7:0]        r_rx_shift;
  logic              r_rx_bad;
  logic              r_push;
  logic              r_frame_err;
  logic              w_rxd;
  logic              w_rx_bit_end;
  logic              w_empty;
  logic              w_full;

  assign w_rxd        = r_sync2;
  assign w_rx_bit_end = (r_rx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_rx_state  <= ST_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_bad    <= 1'b0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= serial_rxd;
      r_sync2     <= r_sync1;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        ST_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bad <= 1'b0;
          if (!w_rxd) r_rx_state <= ST_START;
        end
        ST_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= w_rxd ? ST_IDLE : ST_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
            if (r_rx_bit == 3'd7) r_rx_state <= ST_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // After a bad stop bit, hold here until the line returns high.
          if (r_rx_bad) begin
            if (w_rxd) begin
              r_rx_bad   <= 1'b0;
              r_rx_state <= ST_IDLE;
            end
          end else if (w_rx_bit_end) begin
            r_rx_cnt <= '0;
            if (w_rxd) begin
              r_push     <= 1'b1;
              r_rx_state <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_rx_bad    <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  usb_uart_fifo #(
    .WIDTH (BYTE_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_push),
    .pop   (usb.usb_tx_strobe),
    .din   (r_rx_shift),
    .dout  (usb.usb_tx_data),
    .empty (w_empty),
    .full  (w_full)
  );

  assign usb.usb_tx_strobe = !reset && !w_empty && usb.usb_tx_ready;
  assign rx_overrun        = r_push && w_full;
  assign rx_frame_err      = r_frame_err;

endmodule

// File: tb/tb_usb_uart_bridge.sv
// Directed bench for usb_uart_bridge at CLKS_PER_BIT=8: TX framing, RX
// receive, FIFO overrun, framing error, glitch rejection and mid-frame reset.
module tb_usb_uart_bridge;
  import usb_uart_bridge_pkg::*;

  localparam int CPB = 8;

  logic clk;
  logic reset;
  logic serial_txd;
  logic serial_rxd;
  logic rx_overrun;
  logic rx_frame_err;

  usb_uart_bridge_if usb_if ();

  usb_uart_bridge #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .usb          (usb_if),
    .serial_txd   (serial_txd),
    .serial_rxd   (serial_rxd),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_rx_strobe = 0;
  int         n_ovr = 0;
  int         n_ferr = 0;
  logic [7:0] tx_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor: samples one cycle's outputs just after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (usb_if.usb_rx_strobe) n_rx_strobe++;
    if (rx_overrun)           n_ovr++;
    if (rx_frame_err)         n_ferr++;
    if (usb_if.usb_tx_strobe) tx_q.push_back(usb_if.usb_tx_data);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      serial_rxd = f[s];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    serial_rxd = 1'b1;
    repeat (11) @(negedge clk);
    $display("serial rx byte 0x%02h stop=%0d driven", b, stop);
  endtask

  // Expects usb_rx_ready already high; waits for the strobe, then checks all 10 bit slots.
  task automatic check_tx_frame(input logic [7:0] b, input string tag);
    int         guard;
    logic [9:0] f;
    logic [7:0] samples;
    guard = 0;
    while (!usb_if.usb_rx_strobe && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_eq({tag, "_strobe"}, 32'(usb_if.usb_rx_strobe), 32'd1);
    f = {1'b1, b, 1'b0};
    for (int s = 0; s < 10; s++) begin
      samples = '0;
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        if (s == 0 && k == 0) usb_if.usb_rx_ready = 1'b0;
        #1;
        samples[k] = serial_txd;
      end
      check_eq($sformatf("%s_slot%0d", tag, s), 32'(samples), 32'(f[s] ? 8'hFF : 8'h00));
    end
    $display("serial tx byte 0x%02h frame checked (%s)", b, tag);
  endtask

  int qb, ob, fb, sb;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset                = 1'b1;
    serial_rxd           = 1'b1;
    usb_if.usb_rx_data   = 8'h00;
    usb_if.usb_rx_ready  = 1'b0;
    usb_if.usb_tx_ready  = 1'b0;
    idle(2);
    #1;
    check_eq("rst_txd",       32'(serial_txd),           32'd1);
    check_eq("rst_rx_strobe", 32'(usb_if.usb_rx_strobe), 32'd0);
    check_eq("rst_tx_strobe", 32'(usb_if.usb_tx_strobe), 32'd0);
    check_eq("rst_overrun",   32'(rx_overrun),           32'd0);
    check_eq("rst_frame_err", 32'(rx_frame_err),         32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Host byte 0x55 out on serial_txd
    sb = n_rx_strobe;
    @(negedge clk);
    usb_if.usb_rx_data  = 8'h55;
    usb_if.usb_rx_ready = 1'b1;
    #1;
    check_tx_frame(8'h55, "tx55");
    idle(4);
    check_eq("tx55_strobe_count", 32'(n_rx_strobe - sb), 32'd1);

    // Serial byte 0xA3 delivered to host
    qb = tx_q.size(); ob = n_ovr; fb = n_ferr;
    @(negedge clk);
    usb_if.usb_tx_ready = 1'b1;
    send_serial(8'hA3, 1'b1);
    idle(20);
    check_eq("rxA3_count", 32'(tx_q.size() - qb), 32'd1);
    if (tx_q.size() > qb) check_eq("rxA3_data", 32'(tx_q[qb]), 32'hA3);
    check_eq("rxA3_overrun", 32'(n_ovr - ob),  32'd0);
    check_eq("rxA3_ferr",    32'(n_ferr - fb), 32'd0);

    // 17 bytes with host not ready: 16 kept, last one overruns
    @(negedge clk);
    usb_if.usb_tx_ready = 1'b0;
    qb = tx_q.size(); ob = n_ovr;
    for (int i = 0; i < 17; i++) send_serial(8'(i), 1'b1);
    idle(20);
    #1;
    check_eq("ovr_pulses",    32'(n_ovr - ob),           32'd1);
    check_eq("ovr_no_pop",    32'(tx_q.size() - qb),     32'd0);
    check_eq("ovr_head",      32'(usb_if.usb_tx_data),   32'h00);
    check_eq("ovr_tx_strobe", 32'(usb_if.usb_tx_strobe), 32'd0);
    @(negedge clk);
    usb_if.usb_tx_ready = 1'b1;
    idle(25);
    check_eq("drain_count", 32'(tx_q.size() - qb), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (qb + i < tx_q.size())
        check_eq($sformatf("drain_%0d", i), 32'(tx_q[qb + i]), 32'(i));
    end

    // Bad stop bit on 0x7E, then a clean 0x12
    qb = tx_q.size(); ob = n_ovr; fb = n_ferr;
    send_serial(8'h7E, 1'b0);
    idle(20);
    check_eq("ferr_pulses",  32'(n_ferr - fb),       32'd1);
    check_eq("ferr_no_push", 32'(tx_q.size() - qb),  32'd0);
    send_serial(8'h12, 1'b1);
    idle(20);
    check_eq("after_ferr_count", 32'(tx_q.size() - qb), 32'd1);
    if (tx_q.size() > qb) check_eq("after_ferr_data", 32'(tx_q[qb]), 32'h12);
    check_eq("after_ferr_ferr", 32'(n_ferr - fb), 32'd1);
    check_eq("after_ferr_ovr",  32'(n_ovr - ob),  32'd0);

    // 3-cycle low glitch is rejected
    qb = tx_q.size(); ob = n_ovr; fb = n_ferr;
    @(negedge clk);
    serial_rxd = 1'b0;
    idle(3);
    serial_rxd = 1'b1;
    idle(20);
    $display("serial rx 3-cycle glitch driven");
    check_eq("glitch_no_push", 32'(tx_q.size() - qb), 32'd0);
    check_eq("glitch_ferr",    32'(n_ferr - fb),      32'd0);
    check_eq("glitch_ovr",     32'(n_ovr - ob),       32'd0);
    check_eq("glitch_state",   32'(dut.r_rx_state),   32'(ST_IDLE));
    send_serial(8'h5A, 1'b1);
    idle(20);
    check_eq("glitch_next_count", 32'(tx_q.size() - qb), 32'd1);
    if (tx_q.size() > qb) check_eq("glitch_next_data", 32'(tx_q[qb]), 32'h5A);

    // Reset in the middle of a TX data bit, host keeps ready high
    @(negedge clk);
    usb_if.usb_rx_data  = 8'hC3;
    usb_if.usb_rx_ready = 1'b1;
    #1;
    sb = 0;
    while (!usb_if.usb_rx_strobe && sb < 20) begin
      @(negedge clk);
      #1;
      sb++;
    end
    check_eq("midtx_strobe", 32'(usb_if.usb_rx_strobe), 32'd1);
    idle(20);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_eq("midtx_rst_txd",    32'(serial_txd),           32'd1);
    check_eq("midtx_rst_strobe", 32'(usb_if.usb_rx_strobe), 32'd0);
    idle(2);
    reset = 1'b0;
    #1;
    check_tx_frame(8'hC3, "restart");

    idle(5);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
